// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage register file with retire counter
//
// Purpose:
//   Write-back end of the MEM/WB pipeline register. Selects the write-back
//   data, commits it to a 32 x 32-bit integer register file (x0 hardwired to
//   zero), serves two combinational read ports for the ID stage and counts
//   retired register writes.
//
// Ports:
//   clk     in  1   clock, rising edge
//   clrn    in  1   asynchronous active-low reset
//   wwreg   in  1   WB-stage register-write enable
//   wm2reg  in  1   1 = write wm, 0 = write wal
//   wm      in  32  load data
//   wal     in  32  ALU result
//   wrd     in  5   destination register index
//   rna     in  5   read port A index
//   rnb     in  5   read port B index
//   qa      out 32  read port A data
//   qb      out 32  read port B data
//   wdi     out 32  selected write-back data (to forwarding network)
//   wcnt    out 32  retired register write count (wraps silently)
//
// Configuration:
//   WB_REGFILE_BYPASS_EN  defined: a read of the register being written in
//                         the current cycle returns wdi (write-through).
//                         undefined: such a read returns the old contents.

module wb_regfile (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wwreg,
    input  logic        wm2reg,
    input  logic [31:0] wm,
    input  logic [31:0] wal,
    input  logic [4:0]  wrd,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] wdi,
    output logic [31:0] wcnt
);

    logic [31:0] regs [0:31];
    logic [31:0] wcnt_q;
    logic        we;

    // Write-back select is stateless and valid regardless of wwreg.
    assign wdi = wm2reg ? wm : wal;

    // Writes to x0 are dropped and not counted.
    assign we = wwreg && (wrd != 5'd0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            wcnt_q <= 32'd0;
        end else if (we) begin
            regs[wrd] <= wdi;
            wcnt_q    <= wcnt_q + 32'd1;
        end
    end

    assign wcnt = wcnt_q;

    always_comb begin
        qa = 32'd0;
        qb = 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
        // Write-through: the register being written reads as its new value
        // before the edge, so ID needs no extra stall for the WB hazard.
        if (rna != 5'd0) begin
            qa = (we && (rna == wrd)) ? wdi : regs[rna];
        end
        if (rnb != 5'd0) begin
            qb = (we && (rnb == wrd)) ? wdi : regs[rnb];
        end
`else
        if (rna != 5'd0) begin
            qa = regs[rna];
        end
        if (rnb != 5'd0) begin
            qb = regs[rnb];
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile

module tb_wb_regfile;

    logic        clk;
    logic        clrn;
    logic        wwreg;
    logic        wm2reg;
    logic [31:0] wm;
    logic [31:0] wal;
    logic [4:0]  wrd;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] wdi;
    logic [31:0] wcnt;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk    (clk),
        .clrn   (clrn),
        .wwreg  (wwreg),
        .wm2reg (wm2reg),
        .wm     (wm),
        .wal    (wal),
        .wrd    (wrd),
        .rna    (rna),
        .rnb    (rnb),
        .qa     (qa),
        .qb     (qb),
        .wdi    (wdi),
        .wcnt   (wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One write cycle: drive at negedge, commit at posedge, drop enable after.
    task automatic do_write(input logic [4:0] rd, input logic sel,
                            input logic [31:0] m, input logic [31:0] a);
        @(negedge clk);
        wwreg  = 1'b1;
        wrd    = rd;
        wm2reg = sel;
        wm     = m;
        wal    = a;
        @(posedge clk);
        #1;
        wwreg  = 1'b0;
    endtask

    logic [31:0] rdw_exp;

    initial begin
        clrn   = 1'b1;
        wwreg  = 1'b0;
        wm2reg = 1'b0;
        wm     = 32'd0;
        wal    = 32'd0;
        wrd    = 5'd0;
        rna    = 5'd0;
        rnb    = 5'd0;

        // Reset mid-cycle with no clock edge: everything reads 0 at once.
        #3;
        clrn   = 1'b0;
        wm2reg = 1'b1;
        wm     = 32'hA5A5_0001;
        wal    = 32'h5A5A_0002;
        #1;
        chk("reset_wcnt", wcnt, 32'd0);
        chk("reset_wdi_follows", wdi, 32'hA5A5_0001);
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i);
            rnb = 5'(31 - i);
            #1;
            chk($sformatf("reset_qa_x%0d", i), qa, 32'd0);
            chk($sformatf("reset_qb_x%0d", 31 - i), qb, 32'd0);
        end

        @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rna = 5'd5;
        rnb = 5'd31;
        #1;
        chk("post_reset_qa", qa, 32'd0);
        chk("post_reset_qb", qb, 32'd0);
        chk("post_reset_wcnt", wcnt, 32'd0);

        // Write-back select, memory path.
        do_write(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
        rna = 5'd5;
        #1;
        chk("sel_mem_qa", qa, 32'hDEAD_BEEF);
        chk("sel_mem_wcnt", wcnt, 32'd1);

        // Write-back select, ALU path.
        do_write(5'd6, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        rnb = 5'd6;
        #1;
        chk("sel_alu_qb", qb, 32'h1234_5678);
        chk("sel_alu_wcnt", wcnt, 32'd2);
        chk("sel_alu_qa_x5_kept", qa, 32'hDEAD_BEEF);

        // x0 protection.
        do_write(5'd0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        rna = 5'd0;
        #1;
        chk("x0_qa", qa, 32'd0);
        chk("x0_wcnt", wcnt, 32'd2);

        // Read-during-write.
        do_write(5'd7, 1'b0, 32'd0, 32'h1111_1111);
        @(negedge clk);
        wwreg  = 1'b1;
        wrd    = 5'd7;
        wm2reg = 1'b0;
        wal    = 32'h2222_2222;
        rna    = 5'd7;
        rnb    = 5'd7;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        rdw_exp = 32'h2222_2222;
`else
        rdw_exp = 32'h1111_1111;
`endif
        chk("rdw_before_qa", qa, rdw_exp);
        chk("rdw_before_qb", qb, rdw_exp);
        @(posedge clk);
        #1;
        wwreg = 1'b0;
        #1;
        chk("rdw_after_qa", qa, 32'h2222_2222);
        chk("rdw_after_qb", qb, 32'h2222_2222);
        chk("rdw_wcnt", wcnt, 32'd4);

        // Reset mid-operation: fresh reset, fill x1..x31, then reset on a write.
        @(negedge clk);
        clrn = 1'b0;
        #2;
        clrn = 1'b1;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 1'b0, 32'd0, 32'hC000_0000 + 32'(i * 17));
        end
        chk("fill_wcnt", wcnt, 32'd31);
        rna = 5'd9;
        rnb = 5'd31;
        #1;
        chk("fill_x9", qa, 32'hC000_0000 + 32'd153);
        chk("fill_x31", qb, 32'hC000_0000 + 32'd527);

        @(negedge clk);
        wwreg  = 1'b1;
        wrd    = 5'd9;
        wm2reg = 1'b0;
        wal    = 32'h9999_9999;
        #4;
        clrn   = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_wcnt", wcnt, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i);
            rnb = 5'(i);
            #1;
            chk($sformatf("midrst_qa_x%0d", i), qa, 32'd0);
            chk($sformatf("midrst_qb_x%0d", i), qb, 32'd0);
        end
        @(negedge clk);
        wwreg = 1'b0;
        clrn  = 1'b1;
        @(posedge clk);
        #1;
        rna = 5'd9;
        #1;
        chk("midrst_x9_lost", qa, 32'd0);
        chk("midrst_wcnt_after", wcnt, 32'd0);

        // Counter wrap from a preloaded value.
        @(negedge clk);
        force dut.wcnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.wcnt_q;
        do_write(5'd3, 1'b0, 32'd0, 32'h0000_0033);
        chk("wrap_1", wcnt, 32'hFFFF_FFFF);
        do_write(5'd4, 1'b1, 32'h0000_0044, 32'd0);
        chk("wrap_2", wcnt, 32'h0000_0000);
        do_write(5'd3, 1'b0, 32'd0, 32'h0000_0333);
        chk("wrap_3", wcnt, 32'h0000_0001);
        rna = 5'd3;
        rnb = 5'd4;
        #1;
        chk("wrap_x3", qa, 32'h0000_0333);
        chk("wrap_x4", qb, 32'h0000_0044);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

- Write-back end of the MEM/WB pipeline register.
- Consumes the WB-stage signals (`wwreg`, `wm2reg`, `wm`, `wal`, `wrd`) and selects the write-back data.
- Commits that data into a 32 x 32-bit integer register file, which serves the two combinational read ports used by the ID stage.
- Also keeps a retired-writeback counter for performance monitoring.

## Interface
Parameters:
- none; register count (32) and data width (32) are fixed by the ISA.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `wwreg` in 1: WB-stage register-write enable.
- `wm2reg` in 1: 1 = write memory data `wm`; 0 = write ALU result `wal`.
- `wm` in 32: load data from MEM/WB.
- `wal` in 32: ALU result from MEM/WB.
- `wrd` in 5: destination register index.
- `rna` in 5: read port A index (rs1).
- `rnb` in 5: read port B index (rs2).
- `qa` out 32: read port A data.
- `qb` out 32: read port B data.
- `wdi` out 32: selected write-back data, exported to the forwarding network.
- `wcnt` out 32: count of retired register writes.

## Operation
- Write-back select:
  - `wdi = wm2reg ? wm : wal`.
  - This path is purely combinational and is valid whether or not `wwreg` is set.
- Register write:
  - Happens on the rising `clk` edge when `wwreg`=1 and `wrd`!=0.
  - `regs[wrd] <= wdi`.
  - A write with `wrd`=0 is discarded. x0 always reads 0.
- Reads:
  - Combinational.
  - `qa` = `rna`==0 ? 0 : `regs[rna]`.
  - `qb` = `rnb`==0 ? 0 : `regs[rnb]`.
  - Read-during-write behaviour is set by the configuration macro (see Configuration).
- Retire counter:
  - `wcnt` increments by 1 on each rising edge where `wwreg`=1 and `wrd`!=0.
  - Writes to x0 are not counted.
  - Wraps from 0xFFFFFFFF to 0x00000000 with no flag.
- Reset:
  - While `clrn`=0, regs[1..31] = 0 and `wcnt` = 0, asynchronously and regardless of `clk`.
  - `qa`, `qb` therefore read 0.
  - `wdi` still follows its inputs, because it has no state.
  - Reset asserted in the same cycle as a write wins; the write is lost.
- Simultaneous events:
  - Both read ports may address the same register, or the register being written; each port resolves independently.
  - `wwreg`=1 with X/unknown `wrd` is not supported; the upstream MEM/WB register guarantees clean values after reset.

## Timing
- Write latency: 1 cycle. A value written at edge N is visible on `qa`/`qb` immediately after edge N.
- Read latency: 0 cycles (combinational from `rna`/`rnb` and register contents).
- `wcnt` updates at the same edge as the register write it counts.
- Reset release: the first write is accepted at the first rising edge after `clrn` rises. Meeting recovery time is the integration's responsibility.
- Critical path: `wm2reg` -> `wdi` mux -> bypass mux -> `qa`/`qb`. This path exists only when bypass is compiled in, and must close within the ID-stage budget.

## Configuration
- `WB_REGFILE_BYPASS_EN` defined: internal write-through.
  - When `wwreg`=1, `wrd`!=0 and `rna`==`wrd`, `qa` = `wdi` in the same cycle, before the edge.
  - `qb` is identical with `rnb`.
  - This removes the WB->ID hazard; the hazard unit may drop its extra stall.
- `WB_REGFILE_BYPASS_EN` undefined:
  - A read of the register being written returns the old contents until the edge.
  - The pipeline must forward or stall for that case.

## Test plan
- Reset with no writes:
  - Drive `clrn`=0 mid-cycle with no clock edge.
  - Required: `qa`=`qb`=0 for every index and `wcnt`=0 immediately.
  - After release, with no writes, values stay 0.
- Write-back select:
  - `wwreg`=1, `wrd`=5, `wm`=0xDEADBEEF, `wal`=0x12345678, `wm2reg`=1; one edge; `rna`=5.
  - Required: `qa`=0xDEADBEEF, `wcnt`=1.
  - Repeat with `wm2reg`=0 and `wrd`=6: `qb`(`rnb`=6)=0x12345678, `wcnt`=2.
- x0 protection:
  - `wwreg`=1, `wrd`=0, `wal`=0xFFFFFFFF, `wm2reg`=0; one edge.
  - Required: `qa`(`rna`=0)=0 and `wcnt` unchanged.
- Read-during-write:
  - regs[7]=0x11111111; in one cycle drive `wwreg`=1, `wrd`=7, `wal`=0x22222222, `wm2reg`=0, `rna`=`rnb`=7.
  - With macro: `qa`=`qb`=0x22222222 before the edge.
  - Without macro: `qa`=`qb`=0x11111111 before the edge.
  - Both builds: `qa`=`qb`=0x22222222 after the edge.
- Reset mid-operation:
  - Fill regs[1..31] with distinct values and set `wcnt`=31.
  - Assert `clrn`=0 coincident with a write to x9.
  - Required: every read = 0, `wcnt`=0, and the x9 write is not retained after release.
- Counter wrap:
  - Preload `wcnt` to 0xFFFFFFFE by force or by long run, then perform 3 valid writes.
  - Required: `wcnt` sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
